bmp_stream_writer: RTL and testbench
====================================

# bmp_stream_writer

Hardware BMP serializer on the output side of the Sobel pipeline. It pops 8-bit grayscale edge pixels from the result FIFO and pushes a complete 24-bit BMP byte stream into a downstream byte FIFO: 54-byte header, pixel triplets and row padding. With the fill option compiled in, it also emits the border rows the filter does not produce. It replaces the software grayscale-to-triplet conversion with synthesizable logic feeding a UART/DMA byte sink.

## Interface
- WIDTH, 720, image width in pixels
- HEIGHT, 720, source image height in rows
- FILL_ROWS, 2, rows consumed by the filter window and never output by the pipeline
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_rd_en  out  1  pop strobe to grayscale FIFO (first-word-fall-through)
- in_dout  in  8  grayscale pixel, valid while in_empty=0
- in_empty  in  1  grayscale FIFO empty
- out_wr_en  out  1  push strobe to byte FIFO
- out_din  out  8  byte being pushed
- out_full  in  1  byte FIFO full
- done  out  1  whole file emitted; held high until reset

## Operation
- Derived constants:
  - ROW_BYTES = WIDTH*3 rounded up to a multiple of 4.
  - PAD = ROW_BYTES - WIDTH*3.
  - OUT_H = HEIGHT with BORDER_FILL_EN, else HEIGHT-FILL_ROWS.
  - IMG_SIZE = ROW_BYTES*OUT_H.
  - All size fields are 32-bit unsigned.
- States: HEADER -> PIXEL -> PAD -> (PIXEL | FILL | DONE).
- HEADER: bytes 0..53 emitted in order, all multi-byte fields little-endian.
  - Bytes 0-1: 0x42, 0x4D.
  - Bytes 2-5: 54+IMG_SIZE. Bytes 6-9: 0.
  - Bytes 10-13: 54. Bytes 14-17: 40.
  - Bytes 18-21: WIDTH. Bytes 22-25: OUT_H.
  - Bytes 26-27: 1. Bytes 28-29: 24. Bytes 30-33: 0.
  - Bytes 34-37: IMG_SIZE. Bytes 38-41 and 42-45: 2835.
  - Bytes 46-53: 0.
- PIXEL: phase 0/1/2 each emits in_dout (B, G, R).
  - in_rd_en pulses together with the phase-2 write. Exactly one pop per pixel.
  - After WIDTH pixels, go to PAD if PAD>0, else end the row.
- PAD: emits PAD bytes of 0x00, then ends the row.
- Row end: after (HEIGHT-FILL_ROWS) input rows, go to FILL if enabled, else DONE.
- FILL: emits FILL_ROWS*ROW_BYTES bytes of 0x00, then DONE.
- DONE: no further strobes. done=1. Only reset leaves this state.
- Transfer rule: out_wr_en = byte_available && !out_full.
  - byte_available is always true in HEADER/PAD/FILL.
  - In PIXEL it is !in_empty.
  - Counters and phase advance only on out_wr_en=1.

## Timing
- out_wr_en, out_din and in_rd_en are combinational from state/counters and the FIFO flags. Zero-cycle handshake, one byte per clock at full rate.
- First header byte is presented in the first clock after rst deasserts.
- While rst=1:
  - out_wr_en=0, in_rd_en=0, out_din=0x00, done=0.
  - State returns to HEADER, byte index 0, phase 0, row/col 0.
- Reset mid-file abandons the file; no partial pop is issued. The next file restarts at byte 0.
- out_full rises mid-triplet: hold the current phase and pixel, no pop; resume the same byte when it clears.
- in_empty=1 in PIXEL: stall with no write and no pop. in_empty is ignored in the other states.
- If out_full and in_empty are both asserted, no strobe.
- Counters do not wrap. Each terminal count causes a state change.
- done rises on the clock edge that completes the last byte's write.

## Configuration
- BORDER_FILL_EN defined: OUT_H=HEIGHT and FILL state present. The appended zero rows keep the file at the original image height.
- Undefined: OUT_H=HEIGHT-FILL_ROWS. The FILL state and its counter are not synthesized. DONE follows the last input row's PAD.

## Test plan
- Header, 720x720 with BORDER_FILL_EN, no stalls:
  - Bytes 2-5 = 36 BB 17 00; bytes 22-25 = D0 02 00 00; bytes 34-37 = 00 BB 17 00.
  - Without the macro: bytes 2-5 = 56 AA 17 00 and bytes 22-25 = CE 02 00 00.
- Pixel 0x5A at FIFO head: bytes 5A 5A 5A written on three consecutive clocks. in_rd_en is high only on the third.
- out_full held for 10 cycles after the G byte: no out_wr_en and no in_rd_en during the hold. Next write is the R byte, same value.
- WIDTH=3, HEIGHT=4, FILL_ROWS=2:
  - Each row is 9 pixel bytes followed by 3 zero bytes.
  - Total bytes: 54+24 without the macro, 54+48 with it.
  - done is high after the last byte.
- in_empty toggled every other cycle through a full 720x720 run: byte count matches the header file size, 1,555,254 with the macro.
- rst asserted during row 5, phase 1: strobes go to 0 immediately. After release, output restarts with 0x42, 0x4D, and no extra pop was issued.

Source files
------------

// File: rtl/bmp_stream_writer.sv
// Serialises 8-bit grayscale pixels into a 24-bit BMP byte stream (header, BGR triplets, row padding).
// Optional macro BORDER_FILL_EN appends FILL_ROWS zero rows so the file keeps the source image height.
module bmp_stream_writer #(
  parameter int WIDTH     = 720,
  parameter int HEIGHT    = 720,
  parameter int FILL_ROWS = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       in_rd_en,
  input  logic [7:0] in_dout,
  input  logic       in_empty,
  output logic       out_wr_en,
  output logic [7:0] out_din,
  input  logic       out_full,
  output logic       done
);

  localparam int ROW_BYTES = ((WIDTH * 3 + 3) / 4) * 4;
  localparam int PAD       = ROW_BYTES - WIDTH * 3;
  localparam int IN_ROWS   = HEIGHT - FILL_ROWS;
`ifdef BORDER_FILL_EN
  localparam int OUT_H      = HEIGHT;
  localparam int FILL_BYTES = FILL_ROWS * ROW_BYTES;
  localparam int FILL_W     = (FILL_BYTES > 1) ? $clog2(FILL_BYTES) : 1;
`else
  localparam int OUT_H      = IN_ROWS;
`endif
  localparam logic [31:0] IMG_SIZE  = 32'(ROW_BYTES * OUT_H);
  localparam logic [31:0] FILE_SIZE = 32'd54 + IMG_SIZE;
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;

  typedef enum logic [2:0] {ST_HEADER, ST_PIXEL, ST_PAD, ST_FILL, ST_DONE} state_t;

  // Header bytes 2..53 are thirteen little-endian words; bytes 26..29 pack planes=1 and bpp=24.
  function automatic logic [31:0] hdr_field(input int g);
    case (g)
      0:       hdr_field = FILE_SIZE;
      2:       hdr_field = 32'd54;
      3:       hdr_field = 32'd40;
      4:       hdr_field = 32'(WIDTH);
      5:       hdr_field = 32'(OUT_H);
      6:       hdr_field = 32'h0018_0001;
      8:       hdr_field = IMG_SIZE;
      9, 10:   hdr_field = 32'd2835;
      default: hdr_field = 32'd0;
    endcase
  endfunction

  logic [7:0] hdr_rom [64];

  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_hdr
      if (gi == 0) begin : g_b
        assign hdr_rom[gi] = 8'h42;
      end else if (gi == 1) begin : g_m
        assign hdr_rom[gi] = 8'h4D;
      end else if (gi < 54) begin : g_field
        assign hdr_rom[gi] = 8'(hdr_field((gi - 2) / 4) >> (8 * ((gi - 2) % 4)));
      end else begin : g_zero
        assign hdr_rom[gi] = 8'h00;
      end
    end
  endgenerate

  state_t             state_reg, state_next;
  logic [5:0]         cnt_reg, cnt_next;
  logic [1:0]         phase_reg, phase_next;
  logic [COL_W-1:0]   col_reg, col_next;
  logic [ROW_W-1:0]   row_reg, row_next;
`ifdef BORDER_FILL_EN
  logic [FILL_W-1:0]  fill_reg, fill_next;
`endif

  logic             last_row;
  logic [ROW_W-1:0] row_after;
  state_t           row_end_state;

  assign last_row  = (row_reg == ROW_W'(IN_ROWS - 1));
  assign row_after = last_row ? row_reg : row_reg + ROW_W'(1);
`ifdef BORDER_FILL_EN
  assign row_end_state = last_row ? ((FILL_BYTES > 0) ? ST_FILL : ST_DONE) : ST_PIXEL;
`else
  assign row_end_state = last_row ? ST_DONE : ST_PIXEL;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_HEADER;
      cnt_reg   <= '0;
      phase_reg <= '0;
      col_reg   <= '0;
      row_reg   <= '0;
`ifdef BORDER_FILL_EN
      fill_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
`ifdef BORDER_FILL_EN
      fill_reg  <= fill_next;
`endif
    end
  end

  // Strobes are gated by rst so nothing is pushed or popped while reset is held.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    phase_next = phase_reg;
    col_next   = col_reg;
    row_next   = row_reg;
`ifdef BORDER_FILL_EN
    fill_next  = fill_reg;
`endif
    out_wr_en  = 1'b0;
    in_rd_en   = 1'b0;
    out_din    = 8'h00;
    if (!rst) begin
      case (state_reg)
        ST_HEADER: begin
          out_din   = hdr_rom[cnt_reg];
          out_wr_en = !out_full;
          if (out_wr_en) begin
            if (cnt_reg == 6'd53) begin
              cnt_next   = '0;
              state_next = ST_PIXEL;
            end else begin
              cnt_next = cnt_reg + 6'd1;
            end
          end
        end
        ST_PIXEL: begin
          out_din   = in_dout;
          out_wr_en = !in_empty && !out_full;
          if (out_wr_en) begin
            if (phase_reg == 2'd2) begin
              in_rd_en   = 1'b1;
              phase_next = '0;
              if (col_reg == COL_W'(WIDTH - 1)) begin
                col_next = '0;
                if (PAD > 0) begin
                  state_next = ST_PAD;
                end else begin
                  state_next = row_end_state;
                  row_next   = row_after;
                end
              end else begin
                col_next = col_reg + COL_W'(1);
              end
            end else begin
              phase_next = phase_reg + 2'd1;
            end
          end
        end
        ST_PAD: begin
          out_wr_en = !out_full;
          if (out_wr_en) begin
            if (cnt_reg == 6'(PAD - 1)) begin
              cnt_next   = '0;
              state_next = row_end_state;
              row_next   = row_after;
            end else begin
              cnt_next = cnt_reg + 6'd1;
            end
          end
        end
`ifdef BORDER_FILL_EN
        ST_FILL: begin
          out_wr_en = !out_full;
          if (out_wr_en) begin
            if (fill_reg == FILL_W'(FILL_BYTES - 1)) begin
              state_next = ST_DONE;
            end else begin
              fill_next = fill_reg + FILL_W'(1);
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign done = !rst && (state_reg == ST_DONE);

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Directed bench: a 3x4 writer checked byte-by-byte across stall/reset scenarios, plus a
// 720x720 writer whose header size fields are compared against hand-computed values.
module tb_bmp_stream_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_rd_en, in_empty, out_wr_en, out_full, done;
  logic [7:0] in_dout, out_din;
  logic       big_rd_en, big_wr_en, big_done;
  logic [7:0] big_din;
  logic       big_empty = 1'b1;
  logic       big_full  = 1'b0;
  logic [7:0] big_dout  = 8'h00;

  logic       empty_force = 1'b0;
  logic [3:0] pix_idx;
  logic [7:0] pix_mem [8];

`ifdef BORDER_FILL_EN
  localparam int          EXP_FILE = 102, EXP_OUTH = 4, EXP_IMG = 48;
  localparam logic [31:0] BIG_FILE = 32'h0017_BB36, BIG_OUTH = 32'd720, BIG_IMG = 32'h0017_BB00;
`else
  localparam int          EXP_FILE = 78, EXP_OUTH = 2, EXP_IMG = 24;
  localparam logic [31:0] BIG_FILE = 32'h0017_AA56, BIG_OUTH = 32'd718, BIG_IMG = 32'h0017_AA20;
`endif

  always #5 clk = ~clk;

  assign in_dout  = pix_mem[pix_idx[2:0]];
  assign in_empty = empty_force | (pix_idx >= 4'd6);

  bmp_stream_writer #(.WIDTH(3), .HEIGHT(4), .FILL_ROWS(2)) dut (
    .clk(clk), .rst(rst), .in_rd_en(in_rd_en), .in_dout(in_dout), .in_empty(in_empty),
    .out_wr_en(out_wr_en), .out_din(out_din), .out_full(out_full), .done(done)
  );

  bmp_stream_writer dut_big (
    .clk(clk), .rst(rst), .in_rd_en(big_rd_en), .in_dout(big_dout), .in_empty(big_empty),
    .out_wr_en(big_wr_en), .out_din(big_din), .out_full(big_full), .done(big_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit rd_seen = 1'b0;
  bit big_rd_seen = 1'b0;
  logic [7:0] bytes_q [$];
  bit         rd_q    [$];
  int         cyc_q   [$];
  bit         done_q  [$];
  logic [7:0] big_q   [$];
  logic [7:0] exp_q   [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte sink and FIFO-pop sampling happen on the falling edge, between driven changes.
  always @(negedge clk) begin
    cyc++;
    rd_seen = in_rd_en;
    if (out_wr_en) begin
      bytes_q.push_back(out_din);
      rd_q.push_back(in_rd_en);
      cyc_q.push_back(cyc);
      done_q.push_back(done);
    end
    if (big_wr_en) big_q.push_back(big_din);
    if (big_rd_en) big_rd_seen = 1'b1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) pix_idx <= 4'd0;
    else if (rd_seen) pix_idx <= pix_idx + 4'd1;
  end

  task automatic push32(input logic [31:0] v);
    for (int k = 0; k < 4; k++) exp_q.push_back(v[8*k +: 8]);
  endtask

  task automatic build_expected();
    exp_q.delete();
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h4D);
    push32(32'(EXP_FILE)); push32(32'd0); push32(32'd54); push32(32'd40);
    push32(32'd3); push32(32'(EXP_OUTH)); push32(32'h0018_0001); push32(32'd0);
    push32(32'(EXP_IMG)); push32(32'd2835); push32(32'd2835); push32(32'd0); push32(32'd0);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++)
        for (int p = 0; p < 3; p++) exp_q.push_back(pix_mem[r*3 + c]);
      for (int p = 0; p < 3; p++) exp_q.push_back(8'h00);
    end
`ifdef BORDER_FILL_EN
    for (int p = 0; p < 24; p++) exp_q.push_back(8'h00);
`endif
  endtask

  task automatic clear_capture();
    bytes_q.delete(); rd_q.delete(); cyc_q.delete(); done_q.delete(); big_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    out_full = 1'b0;
    empty_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_capture();
    rst = 1'b0;
  endtask

  // mode 0: free running; mode 1: out_full hold after the first G byte, then in_empty toggling
  task automatic run_file(input int mode);
    int budget;
    bit hold_done;
    budget = 0;
    hold_done = 1'b0;
    while (!done && budget < 1000) begin
      @(posedge clk); #1;
      budget++;
      if (mode == 1) begin
        if (!hold_done && bytes_q.size() == 56) begin
          hold_done   = 1'b1;
          out_full    = 1'b1;
          empty_force = 1'b0;
          for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("hold_wr_en", out_wr_en, 1'b0);
            check_eq("hold_rd_en", in_rd_en, 1'b0);
            @(posedge clk); #1;
          end
          out_full = 1'b0;
        end else begin
          empty_force = ~empty_force;
        end
      end
    end
    empty_force = 1'b0;
    check_eq("run_timeout_done", done, 1'b1);
  endtask

  task automatic verify_file(input string tag);
    int o;
    bit exp_rd;
    check_eq($sformatf("%s_nbytes", tag), bytes_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < bytes_q.size(); i++) begin
      o = i - 54;
      exp_rd = (i >= 54) && (o / 12 < 2) && (o % 12 < 9) && ((o % 12) % 3 == 2);
      check_eq($sformatf("%s_byte%0d", tag, i), bytes_q[i], exp_q[i]);
      check_eq($sformatf("%s_rd_at%0d", tag, i), rd_q[i], exp_rd);
    end
    check_eq($sformatf("%s_pops", tag), pix_idx, 4'd6);
    check_eq($sformatf("%s_done", tag), done, 1'b1);
    if (done_q.size() > 0)
      check_eq($sformatf("%s_done_before_last", tag), done_q[done_q.size()-1], 1'b0);
    $display("file %s: bytes=%0d pops=%0d done=%0b", tag, bytes_q.size(), pix_idx, done);
  endtask

  initial begin
    int n_before;
    int budget;
    pix_mem[0] = 8'h5A; pix_mem[1] = 8'h11; pix_mem[2] = 8'hC3; pix_mem[3] = 8'h7E;
    pix_mem[4] = 8'h00; pix_mem[5] = 8'hFF; pix_mem[6] = 8'hEE; pix_mem[7] = 8'hEE;
    out_full = 1'b0;
    build_expected();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_wr_en", out_wr_en, 1'b0);
    check_eq("rst_rd_en", in_rd_en, 1'b0);
    check_eq("rst_din", out_din, 8'h00);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_big_wr_en", big_wr_en, 1'b0);
    @(posedge clk); #1;
    clear_capture();
    rst = 1'b0;
    @(negedge clk);
    check_eq("first_byte_wr_en", out_wr_en, 1'b1);
    check_eq("first_byte_din", out_din, 8'h42);

    // Run 0: no stalls
    run_file(0);
    verify_file("run0");
    if (cyc_q.size() > 56) begin
      check_eq("pix0_b_to_r_clocks", cyc_q[56] - cyc_q[54], 2);
      check_eq("pix0_g_no_pop", rd_q[55], 1'b0);
    end
    check_eq("big_nbytes", big_q.size(), 54);
    check_eq("big_no_pop", big_rd_seen, 1'b0);
    if (big_q.size() >= 38) begin
      for (int k = 0; k < 4; k++) begin
        check_eq($sformatf("big_file_size_b%0d", k), big_q[2+k], BIG_FILE[8*k +: 8]);
        check_eq($sformatf("big_height_b%0d", k), big_q[22+k], BIG_OUTH[8*k +: 8]);
        check_eq($sformatf("big_img_size_b%0d", k), big_q[34+k], BIG_IMG[8*k +: 8]);
      end
    end
    n_before = bytes_q.size();
    repeat (10) @(posedge clk);
    #1;
    check_eq("idle_after_done_bytes", bytes_q.size(), n_before);
    check_eq("done_held", done, 1'b1);

    // Run 1: out_full hold after the first G byte, then in_empty toggling
    do_reset();
    run_file(1);
    verify_file("run1");
    if (cyc_q.size() > 56)
      check_eq("hold_gap_ge_11", (cyc_q[56] - cyc_q[55]) >= 11, 1'b1);

    // Run 2: reset during row 1, phase 1, then a clean restart
    do_reset();
    budget = 0;
    while (bytes_q.size() < 67 && budget < 300) begin
      @(posedge clk); #1;
      budget++;
    end
    check_eq("midrst_reached", bytes_q.size(), 67);
    check_eq("midrst_pops_before", pix_idx, 4'd3);
    rst = 1'b1;
    #1;
    check_eq("midrst_wr_en", out_wr_en, 1'b0);
    check_eq("midrst_rd_en", in_rd_en, 1'b0);
    check_eq("midrst_din", out_din, 8'h00);
    check_eq("midrst_done", done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    clear_capture();
    rst = 1'b0;
    run_file(0);
    if (bytes_q.size() > 1) begin
      check_eq("restart_byte0", bytes_q[0], 8'h42);
      check_eq("restart_byte1", bytes_q[1], 8'h4D);
    end
    verify_file("run2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
